// File: rtl/jedro_1_defines.sv
// Shared definitions for the jedro_1 instruction fetch path: default boot
// address, instruction width, IFU state encoding and the prefetch entry layout.
package jedro_1_defines;

    localparam int INSTR_WIDTH = 32;
    localparam int XLEN        = 32;

    localparam logic [XLEN-1:0] BOOT_ADDR_DEF = 32'h0000_0000;

    typedef enum logic {
        IFU_RUN  = 1'b0,
        IFU_HALT = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [XLEN-1:0]        addr;
    } fifo_entry_t;

    // A jump target is only legal when it is word aligned.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/jedro_1_fifo.sv
// Prefetch FIFO for the jedro_1 IFU. Stores {instr, addr} pairs, supports
// push, pop and flush (flush beats push), and presents the head entry from
// registers so the decoder sees flop outputs.
module jedro_1_fifo
    import jedro_1_defines::*;
#(
    parameter int DATA_WIDTH = INSTR_WIDTH,
    parameter int ADDR_WIDTH = XLEN,
    parameter int DEPTH      = 2,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_instr_i,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic                  pop_i,
    output logic [CW-1:0]         count_o,
    output logic [DATA_WIDTH-1:0] head_instr_o,
    output logic [ADDR_WIDTH-1:0] head_addr_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] instr_mem_q, instr_mem_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_mem_q, addr_mem_d;
    logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [DATA_WIDTH-1:0]            head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0]            head_addr_q, head_addr_d;
    logic                             do_push, do_pop;

    // Next-state for storage, pointers and count; the head register is loaded
    // from the post-update storage so it tracks the entry the read pointer
    // will point at after this edge.
    always_comb begin
        instr_mem_d = instr_mem_q;
        addr_mem_d  = addr_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        do_pop      = pop_i && (count_q != '0);
        do_push     = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                instr_mem_d[wr_ptr_q] = push_instr_i;
                addr_mem_d[wr_ptr_q]  = push_addr_i;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        head_instr_d = instr_mem_d[rd_ptr_d];
        head_addr_d  = addr_mem_d[rd_ptr_d];
    end

    // State registers; reset clears storage so the head reads zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_mem_q  <= '0;
            addr_mem_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_instr_q <= '0;
            head_addr_q  <= '0;
        end else begin
            instr_mem_q  <= instr_mem_d;
            addr_mem_q   <= addr_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
        end
    end

    assign count_o      = count_q;
    assign head_instr_o = head_instr_q;
    assign head_addr_o  = head_addr_q;

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit. Keeps the PC, issues reads to a
// single-cycle-latency instruction ROM, buffers returned words with their
// addresses in a prefetch FIFO and hands them to the decoder via valid/ready.
// Jumps flush the buffer and restart fetching at the target.
// Optional: define JEDRO_1_IFU_MISALIGN_EXC_EN to raise misaligned_exc_o on a
// non-word-aligned jump target and park the IFU in HALT until a legal jump.
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter int                    DATA_WIDTH = INSTR_WIDTH,
    parameter int                    ADDR_WIDTH = XLEN,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEF,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  instr_mem_en_o,
    output logic [ADDR_WIDTH-1:0] instr_mem_addr_o,
    input  logic [DATA_WIDTH-1:0] instr_mem_rdata_i,
    output logic [DATA_WIDTH-1:0] dec_instr_o,
    output logic [ADDR_WIDTH-1:0] dec_addr_o,
    output logic                  dec_valid_o,
    input  logic                  dec_ready_i,
    input  logic                  jmp_instr_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic                  misaligned_exc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic                  exc_q, exc_d;

    logic [CW-1:0]         fifo_count;
    logic [CW:0]           occupancy;
    logic                  pop;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] jmp_tgt;
    logic                  jmp_misaligned;

`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
    assign jmp_tgt        = jmp_addr_i;
    assign jmp_misaligned = is_misaligned(jmp_addr_i[1:0]);
`else
    // Without the exception, the low target bits are simply ignored.
    assign jmp_tgt        = jmp_addr_i & ~ADDR_WIDTH'(3);
    assign jmp_misaligned = 1'b0;
`endif

    assign dec_valid_o = (fifo_count != '0);
    assign pop         = dec_valid_o & dec_ready_i;

    // Slots already claimed after this cycle's pop: buffered entries plus the
    // response still on its way back from memory.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    // Request issue is combinational on dec_ready_i so a full FIFO that is
    // being popped can still fetch in the same cycle.
    always_comb begin
        issue = ~rst_i && (state_q == IFU_RUN) && ~jmp_instr_i
                && (occupancy < (CW+1)'(FIFO_DEPTH));
    end

    assign instr_mem_en_o   = issue;
    assign instr_mem_addr_o = pc_q;
    assign misaligned_exc_o = exc_q;

    // PC, FSM and in-flight bookkeeping. A jump wins over issue; a response
    // returning in the jump cycle is dropped by the FIFO flush, and no request
    // is made in the jump cycle, so nothing stale arrives afterwards.
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        inflight_d = issue;
        iss_addr_d = iss_addr_q;
        exc_d      = 1'b0;
        if (jmp_instr_i) begin
            if (jmp_misaligned) begin
                state_d = IFU_HALT;
                exc_d   = 1'b1;
            end else begin
                pc_d    = jmp_tgt;
                state_d = IFU_RUN;
            end
        end else if (issue) begin
            pc_d       = pc_q + ADDR_WIDTH'(4);
            iss_addr_d = pc_q;
        end
    end

    // IFU registers; reset forgets any outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IFU_RUN;
            pc_q       <= BOOT_ADDR;
            inflight_q <= 1'b0;
            iss_addr_q <= BOOT_ADDR;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            iss_addr_q <= iss_addr_d;
            exc_q      <= exc_d;
        end
    end

    jedro_1_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (jmp_instr_i),
        .push_i       (inflight_q),
        .push_instr_i (instr_mem_rdata_i),
        .push_addr_i  (iss_addr_q),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .head_instr_o (dec_instr_o),
        .head_addr_o  (dec_addr_o)
    );

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: a per-cycle vector table for reset
// release, fill/stall and redirect, hand-written corner sequences, and a
// randomized phase checked against an address-stream reference model.
module tb_jedro_1_ifu;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic [31:0] dec_instr;
    logic [31:0] dec_addr;
    logic        dec_valid;
    logic        ready = 1'b0;
    logic        jmp = 1'b0;
    logic [31:0] jaddr = 32'h0;
    logic        exc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jedro_1_ifu dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_mem_en_o    (mem_en),
        .instr_mem_addr_o  (mem_addr),
        .instr_mem_rdata_i (mem_rdata),
        .dec_instr_o       (dec_instr),
        .dec_addr_o        (dec_addr),
        .dec_valid_o       (dec_valid),
        .dec_ready_i       (ready),
        .jmp_instr_i       (jmp),
        .jmp_addr_i        (jaddr),
        .misaligned_exc_o  (exc)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    // Single-cycle-latency instruction ROM.
    always @(posedge clk) mem_rdata <= mem_en ? rom(mem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Inputs change after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic r, input logic rd, input logic j, input logic [31:0] a);
        @(negedge clk);
        rst = r; ready = rd; jmp = j; jaddr = a;
        #1;
    endtask

    typedef struct {
        logic        rst, rdy, jmp;
        logic [31:0] ja;
        logic        en;
        logic [31:0] ma;
        logic        vld;
        logic        chk_head;
        logic [31:0] ins, da;
    } vec_t;

    function automatic vec_t mk(input logic r, rd, j, input logic [31:0] ja,
                                input logic en, input logic [31:0] ma,
                                input logic vld, input logic ch, input logic [31:0] da);
        vec_t v;
        v.rst = r; v.rdy = rd; v.jmp = j; v.ja = ja;
        v.en = en; v.ma = ma; v.vld = vld; v.chk_head = ch;
        v.da = da; v.ins = r ? 32'h0 : rom(da);
        return v;
    endfunction

    initial begin
        vec_t tv[$];
        logic [31:0] exp_req, exp_pop;
        int since, outst;

        // Reset, boot fetch, streaming, stall with full FIFO, pop+issue,
        // redirect to 0x40 with a response in flight.
        tv.push_back(mk(1,1,0,0,      0,32'h00, 0,1,32'h00));
        tv.push_back(mk(1,1,0,0,      0,32'h00, 0,1,32'h00));
        tv.push_back(mk(0,1,0,0,      1,32'h00, 0,0,32'h00));
        tv.push_back(mk(0,1,0,0,      1,32'h04, 0,0,32'h00));
        tv.push_back(mk(0,1,0,0,      1,32'h08, 1,1,32'h00));
        tv.push_back(mk(0,1,0,0,      1,32'h0C, 1,1,32'h04));
        tv.push_back(mk(0,1,0,0,      1,32'h10, 1,1,32'h08));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0,0,0,0,  0,32'h14, 1,1,32'h0C));
        tv.push_back(mk(0,1,0,0,      1,32'h14, 1,1,32'h0C));
        tv.push_back(mk(0,0,1,32'h40, 0,32'h18, 1,1,32'h10));
        tv.push_back(mk(0,1,0,0,      1,32'h40, 0,0,32'h00));
        tv.push_back(mk(0,1,0,0,      1,32'h44, 0,0,32'h00));
        tv.push_back(mk(0,1,0,0,      1,32'h48, 1,1,32'h40));
        tv.push_back(mk(0,1,0,0,      1,32'h4C, 1,1,32'h44));

        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].rdy, tv[i].jmp, tv[i].ja);
            chk($sformatf("v%0d en", i), 32'(mem_en), 32'(tv[i].en));
            if (tv[i].en || tv[i].rst) chk($sformatf("v%0d maddr", i), mem_addr, tv[i].ma);
            chk($sformatf("v%0d valid", i), 32'(dec_valid), 32'(tv[i].vld));
            chk($sformatf("v%0d exc", i), 32'(exc), 32'h0);
            if (tv[i].chk_head) begin
                chk($sformatf("v%0d instr", i), dec_instr, tv[i].ins);
                chk($sformatf("v%0d daddr", i), dec_addr, tv[i].da);
            end
        end

        // Jump together with reset: reset wins, fetch restarts at boot address.
        drive(1,1,1,32'h200);
        chk("jr en", 32'(mem_en), 32'h0);
        drive(0,1,0,0);
        chk("jr en1", 32'(mem_en), 32'h1);
        chk("jr addr1", mem_addr, 32'h0);
        chk("jr valid1", 32'(dec_valid), 32'h0);
        drive(0,1,0,0);
        chk("jr addr2", mem_addr, 32'h4);
        drive(0,1,0,0);
        chk("jr daddr", dec_addr, 32'h0);

        // PC wrap at the top of the address space.
        drive(0,1,1,32'hFFFF_FFF8);
        chk("wrap jen", 32'(mem_en), 32'h0);
        drive(0,1,0,0);
        chk("wrap a0", mem_addr, 32'hFFFF_FFF8);
        drive(0,1,0,0);
        chk("wrap a1", mem_addr, 32'hFFFF_FFFC);
        drive(0,1,0,0);
        chk("wrap a2", mem_addr, 32'h0000_0000);
        chk("wrap d0", dec_addr, 32'hFFFF_FFF8);
        drive(0,1,0,0);
        chk("wrap d1", dec_addr, 32'hFFFF_FFFC);
        drive(0,1,0,0);
        chk("wrap d2", dec_addr, 32'h0);
        chk("wrap i2", dec_instr, 32'h0010_0093);

        // Misaligned jump target.
        drive(0,1,1,32'h42);
        chk("mis jen", 32'(mem_en), 32'h0);
`ifdef JEDRO_1_IFU_MISALIGN_EXC_EN
        drive(0,1,0,0);
        chk("mis exc", 32'(exc), 32'h1);
        chk("mis en", 32'(mem_en), 32'h0);
        chk("mis valid", 32'(dec_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(0,1,0,0);
            chk("mis exc0", 32'(exc), 32'h0);
            chk("mis halt en", 32'(mem_en), 32'h0);
            chk("mis halt valid", 32'(dec_valid), 32'h0);
        end
        drive(0,1,1,32'h80);
        chk("mis jen2", 32'(mem_en), 32'h0);
        drive(0,1,0,0);
        chk("mis resume", mem_addr, 32'h80);
        chk("mis resume en", 32'(mem_en), 32'h1);
        drive(0,1,0,0);
        drive(0,1,0,0);
        chk("mis dvalid", 32'(dec_valid), 32'h1);
        chk("mis daddr", dec_addr, 32'h80);
`else
        drive(0,1,0,0);
        chk("mis exc", 32'(exc), 32'h0);
        chk("mis en", 32'(mem_en), 32'h1);
        chk("mis addr", mem_addr, 32'h40);
        drive(0,1,0,0);
        drive(0,1,0,0);
        chk("mis dvalid", 32'(dec_valid), 32'h1);
        chk("mis daddr", dec_addr, 32'h40);
`endif

        // Randomized phase. Model: requests and deliveries each follow the
        // sequential address stream starting at the last jump target; at most
        // DEPTH words are claimed at any time; valid is steady from N+3.
        drive(0,1,1,32'h100);
        exp_req = 32'h100; exp_pop = 32'h100; since = 1; outst = 0;
        for (int c = 0; c < 3000; c++) begin
            logic rd, j, p;
            logic [31:0] ja;
            rd = ($urandom_range(9) < 7);
            j  = ($urandom_range(24) == 0);
            ja = {$urandom() >> 2, 2'b00};
            if ($urandom_range(3) == 0) ja = 32'hFFFF_FFE0 | {ja[4:2], 2'b00};
            drive(0, rd, j, ja);
            p = dec_valid & rd;
            if (j) chk("rnd jmp en", 32'(mem_en), 32'h0);
            else if (mem_en) begin
                chk("rnd req addr", mem_addr, exp_req);
                exp_req += 32'd4;
            end
            if (since >= 3) chk("rnd valid", 32'(dec_valid), 32'h1);
            if (p) begin
                chk("rnd daddr", dec_addr, exp_pop);
                chk("rnd instr", dec_instr, rom(exp_pop));
                exp_pop += 32'd4;
            end
            outst = outst + int'(mem_en) - int'(p);
            chk("rnd occupancy", 32'(outst <= DEPTH), 32'h1);
            if (j) begin
                exp_req = ja; exp_pop = ja; outst = 0; since = 1;
            end else begin
                since++;
            end
        end

        // Reset in the middle of streaming.
        drive(1,1,0,0);
        chk("mrst en", 32'(mem_en), 32'h0);
        drive(1,1,0,0);
        chk("mrst valid", 32'(dec_valid), 32'h0);
        chk("mrst instr", dec_instr, 32'h0);
        chk("mrst daddr", dec_addr, 32'h0);
        chk("mrst maddr", mem_addr, 32'h0);
        chk("mrst exc", 32'(exc), 32'h0);
        drive(0,1,0,0);
        chk("mrst en1", 32'(mem_en), 32'h1);
        chk("mrst a1", mem_addr, 32'h0);
        drive(0,1,0,0);
        chk("mrst nostale", 32'(dec_valid), 32'h0);
        drive(0,1,0,0);
        chk("mrst valid2", 32'(dec_valid), 32'h1);
        chk("mrst d2", dec_instr, 32'h0010_0093);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
